// File: rtl/led_scan_decoder_if.sv
// Display scan bus: sampled anode/segment lines in, rebuilt digits and status out.
interface led_scan_decoder_if #(
  parameter int ERR_W = 8
);
  logic             a3, a2, a1, a0;
  logic [6:0]       seg;
  logic [3:0]       digit0, digit1, digit2, digit3;
  logic [3:0]       digit_valid;
  logic             frame_done;
  logic             scan_err;
  logic             code_err;
  logic             locked;
  logic [ERR_W-1:0] err_count;

  modport master (
    output a3, a2, a1, a0, seg,
    input  digit0, digit1, digit2, digit3, digit_valid,
    input  frame_done, scan_err, code_err, locked, err_count
  );

  modport slave (
    input  a3, a2, a1, a0, seg,
    output digit0, digit1, digit2, digit3, digit_valid,
    output frame_done, scan_err, code_err, locked, err_count
  );
endinterface

// File: rtl/led_scan_decoder.sv
// Rebuilds four hex digits from a multiplexed active-low 7-seg scan and checks scan order.
// Latency 2 clk input to output at STABLE_CYCLES=1; no backpressure, every sample is consumed.
module led_scan_decoder #(
  parameter int STABLE_CYCLES = 1,
  parameter int ERR_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  led_scan_decoder_if.slave  bus
);
  typedef enum logic {HUNT, TRACK} state_t;

  state_t           state, state_n;
  logic [3:0]       an_q, an_prev;
  logic [6:0]       seg_q, seg_prev;
  logic [7:0]       stab_cnt, cnt_n;
  logic             captured, captured_n, capture;
  logic [1:0]       exp_idx, exp_n, idx;
  logic [3:0]       digit_q [4];
  logic [3:0]       valid_q;
  logic             frame_q, scan_q, code_q;
  logic             frame_n, scan_n, code_n, wr;
  logic [ERR_W-1:0] err_q, err_n;
  logic             onehot, malformed, same_an;
  logic             known;
  logic [3:0]       glyph;

  always_comb begin
    onehot = 1'b1;
    idx    = 2'd0;
    case (an_q)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: onehot = 1'b0;
    endcase
    malformed = !onehot && (an_q != 4'b1111);
  end

  always_comb begin
    known = 1'b1;
    glyph = 4'h0;
    case (seg_q)
      7'h40: glyph = 4'h0;
      7'h79: glyph = 4'h1;
      7'h24: glyph = 4'h2;
      7'h30: glyph = 4'h3;
      7'h19: glyph = 4'h4;
      7'h12: glyph = 4'h5;
      7'h02: glyph = 4'h6;
      7'h78: glyph = 4'h7;
      7'h00: glyph = 4'h8;
      7'h10: glyph = 4'h9;
      7'h08: glyph = 4'hA;
      7'h03: glyph = 4'hB;
      7'h46: glyph = 4'hC;
      7'h21: glyph = 4'hD;
      7'h06: glyph = 4'hE;
      7'h0E: glyph = 4'hF;
      default: known = 1'b0;
    endcase
  end

  // A dwell is a run of one one-hot anode; blank or malformed samples end it.
  always_comb begin
    same_an = (an_q == an_prev);
    if (!onehot)
      cnt_n = 8'd0;
    else if (!same_an || (seg_q != seg_prev))
      cnt_n = 8'd1;
    else if (stab_cnt != 8'hFF)
      cnt_n = stab_cnt + 8'd1;
    else
      cnt_n = stab_cnt;
    capture    = onehot && !(same_an && captured) && (cnt_n == 8'(STABLE_CYCLES));
    captured_n = onehot && ((same_an && captured) || capture);
  end

  always_comb begin
    wr      = 1'b0;
    scan_n  = 1'b0;
    frame_n = 1'b0;
    state_n = state;
    exp_n   = exp_idx;
    if (malformed) begin
      scan_n  = 1'b1;
      state_n = HUNT;
    end else if (capture) begin
      if (state == HUNT) begin
        if (idx == 2'd0) begin
          wr      = 1'b1;
          state_n = TRACK;
          exp_n   = 2'd1;
        end
      end else if (idx == exp_idx) begin
        wr      = 1'b1;
        exp_n   = idx + 2'd1;
        frame_n = (idx == 2'd3);
      end else begin
        scan_n = 1'b1;
        // An early digit 0 is a resync, not a loss of lock.
        if (idx == 2'd0) begin
          wr    = 1'b1;
          exp_n = 2'd1;
        end else begin
          state_n = HUNT;
        end
      end
    end
    code_n = wr && !known;
    err_n  = ((scan_n || code_n) && (err_q != '1)) ? err_q + ERR_W'(1) : err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= HUNT;
      an_q     <= 4'hF;
      an_prev  <= 4'hF;
      seg_q    <= 7'h7F;
      seg_prev <= 7'h7F;
      stab_cnt <= 8'd0;
      captured <= 1'b0;
      exp_idx  <= 2'd0;
      for (int i = 0; i < 4; i++) digit_q[i] <= 4'h0;
      valid_q  <= 4'h0;
      frame_q  <= 1'b0;
      scan_q   <= 1'b0;
      code_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      an_q     <= {bus.a3, bus.a2, bus.a1, bus.a0};
      seg_q    <= bus.seg;
      an_prev  <= an_q;
      seg_prev <= seg_q;
      stab_cnt <= cnt_n;
      captured <= captured_n;
      state    <= state_n;
      exp_idx  <= exp_n;
      frame_q  <= frame_n;
      scan_q   <= scan_n;
      code_q   <= code_n;
      err_q    <= err_n;
      if (wr) begin
        if (known) begin
          digit_q[idx] <= glyph;
          valid_q[idx] <= 1'b1;
        end else begin
          valid_q[idx] <= 1'b0;
        end
      end
    end
  end

  assign bus.digit0      = digit_q[0];
  assign bus.digit1      = digit_q[1];
  assign bus.digit2      = digit_q[2];
  assign bus.digit3      = digit_q[3];
  assign bus.digit_valid = valid_q;
  assign bus.frame_done  = frame_q;
  assign bus.scan_err    = scan_q;
  assign bus.code_err    = code_q;
  assign bus.locked      = (state == TRACK);
  assign bus.err_count   = err_q;
endmodule

// File: tb/tb_led_scan_decoder.sv
// Scoreboarded bench: stimulus queues expected event snapshots, per-DUT monitors pop on each pulse.
module tb_led_scan_decoder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  led_scan_decoder_if #(.ERR_W(8)) if1();
  led_scan_decoder_if #(.ERR_W(8)) if3();

  led_scan_decoder #(.STABLE_CYCLES(1), .ERR_W(8)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  led_scan_decoder #(.STABLE_CYCLES(3), .ERR_W(8)) dut3 (.clk(clk), .reset(reset), .bus(if3));

  int total  = 0;
  int passed = 0;
  logic [31:0] q1[$];
  logic [31:0] q3[$];
  logic [31:0] act1, exp1, act3, exp3;
  logic [3:0]  an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Event snapshot: {frame_done, scan_err, code_err, digit3..digit0, digit_valid, locked, err_count}
  function automatic logic [31:0] ev(logic f, logic s, logic c, logic [15:0] dig,
                                     logic [3:0] val, logic lk, logic [7:0] ec);
    return {f, s, c, dig, val, lk, ec};
  endfunction

  task automatic chk(string name, int act, int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  task automatic drv(int sel, logic [3:0] an, logic [6:0] sg);
    @(posedge clk);
    #1;
    if (sel == 1) begin
      {if1.a3, if1.a2, if1.a1, if1.a0} = an;
      if1.seg = sg;
    end else begin
      {if3.a3, if3.a2, if3.a1, if3.a0} = an;
      if3.seg = sg;
    end
  endtask

  task automatic put(int sel, int idx, logic [6:0] sg);
    drv(sel, an_tab[idx], sg);
  endtask

  task automatic idle(int sel, int n);
    repeat (n) drv(sel, 4'hF, 7'h7F);
  endtask

  task automatic frame1(logic [6:0] s0, logic [6:0] s1, logic [6:0] s2, logic [6:0] s3);
    put(1, 0, s0);
    put(1, 1, s1);
    put(1, 2, s2);
    put(1, 3, s3);
  endtask

  // Settled-dwell frame for the STABLE_CYCLES=3 instance: glitch, 3 settled, blank.
  task automatic dwell3(int idx, logic [6:0] glitch, logic [6:0] good);
    put(3, idx, glitch);
    repeat (3) put(3, idx, good);
    drv(3, 4'hF, 7'h7F);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_digits"}, {if1.digit3, if1.digit2, if1.digit1, if1.digit0}, 0);
    chk({tag, "_valid"}, if1.digit_valid, 0);
    chk({tag, "_pulses"}, {if1.frame_done, if1.scan_err, if1.code_err}, 0);
    chk({tag, "_locked"}, if1.locked, 0);
    chk({tag, "_errcnt"}, if1.err_count, 0);
  endtask

  always @(negedge clk) begin
    if (!reset && (if1.frame_done || if1.scan_err || if1.code_err)) begin
      act1 = {if1.frame_done, if1.scan_err, if1.code_err, if1.digit3, if1.digit2,
              if1.digit1, if1.digit0, if1.digit_valid, if1.locked, if1.err_count};
      total++;
      if (q1.size() == 0) begin
        $display("FAIL mon1_unexpected_event actual=%h required=none", act1);
      end else begin
        exp1 = q1.pop_front();
        if (act1 === exp1) passed++;
        else $display("FAIL mon1_event actual=%h required=%h", act1, exp1);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && (if3.frame_done || if3.scan_err || if3.code_err)) begin
      act3 = {if3.frame_done, if3.scan_err, if3.code_err, if3.digit3, if3.digit2,
              if3.digit1, if3.digit0, if3.digit_valid, if3.locked, if3.err_count};
      total++;
      if (q3.size() == 0) begin
        $display("FAIL mon3_unexpected_event actual=%h required=none", act3);
      end else begin
        exp3 = q3.pop_front();
        if (act3 === exp3) passed++;
        else $display("FAIL mon3_event actual=%h required=%h", act3, exp3);
      end
    end
  end

  initial begin
    {if1.a3, if1.a2, if1.a1, if1.a0} = 4'hF;
    if1.seg = 7'h7F;
    {if3.a3, if3.a2, if3.a1, if3.a0} = 4'hF;
    if3.seg = 7'h7F;
    reset = 1'b1;
    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Basic in-order scan; lock appears two clocks after the first sample
    for (int k = 0; k < 8; k++) begin
      if (k % 4 == 3) q1.push_back(ev(1, 0, 0, 16'h3210, 4'hF, 1, 8'd0));
      put(1, k % 4, (k % 4 == 0) ? 7'h40 : (k % 4 == 1) ? 7'h79 : (k % 4 == 2) ? 7'h24 : 7'h30);
      @(negedge clk);
      chk("lock_rise", if1.locked, (k >= 2) ? 1 : 0);
    end

    // Skipped digit 1: digit2 must not take the '4' glyph
    put(1, 0, 7'h40);
    q1.push_back(ev(0, 1, 0, 16'h3210, 4'hF, 0, 8'd1));
    put(1, 2, 7'h19);
    put(1, 0, 7'h40);
    idle(1, 2);
    @(negedge clk);
    chk("relock_after_skip", if1.locked, 1);
    q1.push_back(ev(1, 0, 0, 16'h3210, 4'hF, 1, 8'd1));
    put(1, 1, 7'h79); put(1, 2, 7'h24); put(1, 3, 7'h30);

    // Malformed anode pattern
    put(1, 0, 7'h40);
    q1.push_back(ev(0, 1, 0, 16'h3210, 4'hF, 0, 8'd2));
    drv(1, 4'b1100, 7'h40);
    q1.push_back(ev(1, 0, 0, 16'h3210, 4'hF, 1, 8'd2));
    frame1(7'h40, 7'h79, 7'h24, 7'h30);

    // Unknown glyph on digit2, then on digit3 together with frame_done
    q1.push_back(ev(0, 0, 1, 16'h3210, 4'b1011, 1, 8'd3));
    q1.push_back(ev(1, 0, 0, 16'h3210, 4'b1011, 1, 8'd3));
    frame1(7'h40, 7'h79, 7'h7F, 7'h30);
    q1.push_back(ev(1, 0, 0, 16'h3210, 4'hF, 1, 8'd3));
    frame1(7'h40, 7'h79, 7'h24, 7'h30);
    q1.push_back(ev(1, 0, 1, 16'h3210, 4'b0111, 1, 8'd4));
    frame1(7'h40, 7'h79, 7'h24, 7'h7F);
    q1.push_back(ev(1, 0, 0, 16'h3210, 4'hF, 1, 8'd4));
    frame1(7'h40, 7'h79, 7'h24, 7'h30);

    // Fifth error, relock partway, then asynchronous reset mid-frame
    put(1, 0, 7'h40);
    q1.push_back(ev(0, 1, 0, 16'h3210, 4'hF, 0, 8'd5));
    drv(1, 4'b1100, 7'h40);
    put(1, 0, 7'h40);
    put(1, 1, 7'h79);
    idle(1, 2);
    @(negedge clk);
    chk("pre_reset_locked", if1.locked, 1);
    chk("pre_reset_errcnt", if1.err_count, 5);
    #2 reset = 1'b1;
    #1;
    chk_zero("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // HUNT ignores digits 1..3 until digit 0 shows up
    put(1, 1, 7'h79); put(1, 2, 7'h24); put(1, 3, 7'h30);
    idle(1, 2);
    @(negedge clk);
    chk("hunt_locked", if1.locked, 0);
    chk("hunt_valid", if1.digit_valid, 0);
    chk("hunt_digits", {if1.digit3, if1.digit2, if1.digit1, if1.digit0}, 0);
    q1.push_back(ev(1, 0, 0, 16'h3210, 4'hF, 1, 8'd0));
    frame1(7'h40, 7'h79, 7'h24, 7'h30);

    // Error counter saturation
    for (int i = 1; i <= 300; i++) begin
      q1.push_back(ev(0, 1, 0, 16'h3210, 4'hF, 0, (i > 255) ? 8'd255 : 8'(i)));
      drv(1, 4'b1100, 7'h40);
    end
    idle(1, 3);
    @(negedge clk);
    chk("errcnt_saturated", if1.err_count, 255);

    // STABLE_CYCLES=3 with glitching first cycle, blanks between digits
    q3.push_back(ev(1, 0, 0, 16'h8765, 4'hF, 1, 8'd0));
    put(3, 0, 7'h79);
    repeat (3) put(3, 0, 7'h12);
    put(3, 0, 7'h24);
    drv(3, 4'hF, 7'h7F);
    dwell3(1, 7'h00, 7'h02);
    dwell3(2, 7'h7F, 7'h78);
    dwell3(3, 7'h40, 7'h00);
    q3.push_back(ev(1, 0, 0, 16'hCBA9, 4'hF, 1, 8'd0));
    dwell3(0, 7'h40, 7'h10);
    dwell3(1, 7'h79, 7'h08);
    dwell3(2, 7'h24, 7'h03);
    dwell3(3, 7'h30, 7'h46);
    idle(3, 3);
    @(negedge clk);
    chk("stable3_locked", if3.locked, 1);
    chk("stable3_errcnt", if3.err_count, 0);

    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/led_scan_decoder.md
Name: led_scan_decoder

Overview:
- Receive-side counterpart of the 4-digit anode-scan display driver.
- Samples the multiplexed active-low anodes (a3..a0) and active-low segment bus, then rebuilds the four displayed hex digits.
- Checks that the scan order is 0,1,2,3,0… and flags malformed scans or unknown glyphs.
- Used for display self-test and readback on the SoC's 7-seg path.

Parameters:
- STABLE_CYCLES, 1: consecutive identical samples of {anodes,seg} required before a capture (range 1..255).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- a3,a2,a1,a0  in  1 each  active-low anode enables; a0 = digit 0
- seg  in  7  active-low cathodes, bit order {g,f,e,d,c,b,a}
- digit0..digit3  out  4 each  last decoded hex value per digit
- digit_valid  out  4  bit n set when digitn holds a recognised glyph
- frame_done  out  1  one-cycle pulse on an in-order digit3 capture
- scan_err  out  1  one-cycle pulse on an anode protocol violation
- code_err  out  1  one-cycle pulse on an unrecognised segment pattern
- locked  out  1  high while in TRACK
- err_count  out  ERR_W  saturating count of error cycles

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - All outputs go to 0; FSM goes to HUNT.
  - Stability counter and "captured" flag are cleared.
- Input stage:
  - {a3..a0,seg} is registered every clk.
  - All decisions use the registered sample.
  - Capture, flag and pulse outputs update one edge later, so latency is 2 clk from input to output at STABLE_CYCLES=1.
- Anode classification of the registered sample:
  - Blank (4'b1111): ignored. No capture, no error, FSM state and expected index held. Stability counter cleared.
  - One-hot-low (1110, 1101, 1011, 0111): digit index 0..3.
  - Any other pattern: malformed. scan_err pulses, FSM goes to HUNT.
- Dwell and capture:
  - A dwell starts when the anode index changes (blank counts as a change).
  - The stability counter counts consecutive identical registered samples. It restarts at 1 when seg changes within a dwell.
  - Capture happens once per dwell, when the counter reaches STABLE_CYCLES.
  - A seg change after capture in the same dwell causes no recapture.
- Glyph decode (seg hex, {g..a}): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F.
  - On capture with a known glyph: digitn is loaded and digit_valid[n] set.
  - On capture with an unknown glyph: digitn is held, digit_valid[n] cleared, code_err pulses. Sequence tracking is unaffected.
- FSM, HUNT:
  - Captures of indexes 1..3 are ignored: no error, no digit update.
  - A capture of index 0 updates digit0, moves to TRACK, and sets expected index to 1.
- FSM, TRACK:
  - A capture at the expected index updates that digit; expected index becomes (index+1) mod 4.
  - A capture of index 3 in TRACK pulses frame_done.
  - A capture at the wrong index pulses scan_err.
    - If the wrong index is 0: resync in place. Capture digit0, stay in TRACK, expected index becomes 1.
    - Otherwise: go to HUNT with no capture.
  - A malformed anode pattern goes to HUNT.
- locked = (state == TRACK).
- err_count:
  - Increments by 1 in any cycle where scan_err or code_err is high (a cycle with both still counts once).
  - Saturates at 2^ERR_W−1.
- Simultaneous events: frame_done and code_err may pulse in the same cycle; the digit3 capture still counts as in-order.

Test Plan:
1. STABLE_CYCLES=1, driver sequence 1110/40, 1101/79, 1011/24, 0111/30, repeated.
   - locked rises 2 clk after first sample.
   - digit0..3 = 0,1,2,3; digit_valid = 4'b1111.
   - frame_done pulses every 4th cycle; err_count = 0.
2. Locked, then skip digit 1 (1110 then 1011).
   - scan_err pulses once; locked falls.
   - digit2 unchanged; err_count = 1.
   - Next 1110 relocks.
3. Locked, then anode 1100 for one cycle.
   - scan_err pulses; state HUNT; err_count increments.
4. Digit2 shown with seg 7F (blank glyph).
   - code_err pulses; digit_valid = 4'b1011; digit2 holds its old value.
   - Tracking stays locked; frame_done still pulses on digit3.
5. STABLE_CYCLES=3, each anode held 4 clk, seg glitching in the first cycle of each dwell.
   - Exactly one capture per dwell, with the settled value.
   - Blank 1111 inserted between digits causes no error.
6. Assert reset mid-frame while locked with err_count = 5.
   - All outputs 0 immediately, without waiting for clk.
   - After release, relock needs digit0.
   - Separately, force 300 errors: err_count sticks at 255.
